tx_frame_scheduler: RTL and testbench
=====================================

TX_FRAME_SCHEDULER -- requirements
Module: tx_frame_scheduler

Interface
REQ-001 The block SHALL have these parameters:
- GAP_CYCLES, 16, idle clocks between the Tx_BUSY fall of one byte and the Tx_WR of the next byte (range 0..255).
- BUSY_TIMEOUT, 64, maximum clocks from Tx_WR to Tx_BUSY rising (range 1..255).
REQ-002 The block SHALL have these ports:
- clock  in  1  single clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- word_in  in  16  hex word to send (digit3 = [15:12] .. digit0 = [3:0]).
- word_valid  in  1  word_in is offered.
- word_ready  out  1  block accepts word_in this cycle.
- Tx_DATA  out  8  byte presented to the UART transmitter.
- Tx_WR  out  1  one-cycle write strobe to the UART.
- Tx_EN  out  1  UART transmitter enable.
- Tx_BUSY  in  1  UART transmitter busy.
- frame_done  out  1  one-cycle pulse when all 4 bytes of a word have been sent.
- frame_err  out  1  one-cycle pulse when a frame is aborted on timeout.
- words_sent  out  8  count of completed frames.

Function
REQ-003 The block SHALL use a state machine with states IDLE, WRITE, WAIT_HI, WAIT_LO, GAP and DONE.
REQ-004 A word SHALL be accepted only on a cycle where word_valid=1 and word_ready=1; word_ready SHALL be 1 only in IDLE.
REQ-005 On acceptance the block SHALL latch word_in into a holding register, set digit index idx=3 and go to WRITE; later changes on word_in SHALL have no effect.
REQ-006 Byte encoding SHALL be Tx_DATA = {idx[1:0], 2'b00, nibble[idx]}; bytes SHALL be sent in the order idx 3, 2, 1, 0.
REQ-007 In WRITE the block SHALL assert Tx_WR for exactly one cycle with Tx_DATA valid in that same cycle, then go to WAIT_HI.
REQ-008 Tx_DATA SHALL stay stable from the WRITE cycle until the next WRITE cycle or IDLE.
REQ-009 In WAIT_HI the block SHALL count clocks.
- Tx_BUSY=1: go to WAIT_LO.
- Count reaches BUSY_TIMEOUT with Tx_BUSY still 0: pulse frame_err for one cycle, drop the remaining bytes, do not increment words_sent, go to IDLE.
REQ-010 In WAIT_LO the block SHALL wait with no timeout until Tx_BUSY=0.
- idx>0: go to GAP.
- idx=0: go to DONE.
REQ-011 GAP SHALL last exactly GAP_CYCLES clocks, then decrement idx and go to WRITE; GAP_CYCLES=0 SHALL go straight from WAIT_LO to WRITE with idx decremented.
REQ-012 DONE SHALL last one cycle: pulse frame_done, increment words_sent (modulo 256, 255 wraps to 0), then go to IDLE.
REQ-013 Tx_EN SHALL be 1 in every state except IDLE.
REQ-014 Tx_WR SHALL never be asserted while Tx_BUSY=1.
- If Tx_BUSY is already 1 on entry to WRITE, the block SHALL hold in WRITE with Tx_WR=0 until Tx_BUSY=0, and the WAIT_HI timeout SHALL not run during that hold.
REQ-015 If word_valid=1 in the DONE cycle, the word SHALL NOT be accepted; the earliest acceptance is the following IDLE cycle.
REQ-016 Minimum frame length with Tx_BUSY high for B clocks per byte SHALL be 4*(1+1+B) + 3*GAP_CYCLES + 1 clocks from acceptance to frame_done, assuming Tx_BUSY rises the clock after Tx_WR.

Reset
REQ-017 While reset=1 at a clock edge, the block SHALL go to IDLE and drive these values: word_ready=1, Tx_WR=0, Tx_EN=0, Tx_DATA=8'h00, frame_done=0, frame_err=0, words_sent=0, idx=3, counters=0.
REQ-018 Reset asserted mid-frame SHALL abort the frame without a frame_done or frame_err pulse, and no Tx_WR SHALL follow until a new word is accepted.

Verification
REQ-019 Nominal word: word_in=16'hA5C3, GAP_CYCLES=16, UART model busy for 10 clocks -> Tx_DATA sequence 8'hCA, 8'h85, 8'h4C, 8'h03; one Tx_WR each; frame_done once; words_sent=1.
REQ-020 Timeout: Tx_BUSY held 0 -> frame_err pulses exactly BUSY_TIMEOUT clocks after the first Tx_WR; only one Tx_WR occurs; words_sent unchanged; word_ready=1 on the next cycle.
REQ-021 Back-to-back frames: word_valid held high with two words -> second acceptance no earlier than the cycle after DONE; gap between frame bytes ≥ GAP_CYCLES; words_sent=2.
REQ-022 Wrap-around: 256 completed frames -> words_sent=8'h00; frame_done pulse count = 256.
REQ-023 Mid-frame reset: reset asserted while in WAIT_LO of byte idx=2 -> all outputs return to their REQ-017 values the next clock; no frame_done or frame_err pulse; the next word starts at idx=3.
REQ-024 GAP_CYCLES=0 with Tx_BUSY already high at WRITE entry -> Tx_WR is delayed until Tx_BUSY=0, no false frame_err occurs, and the frame completes with 4 bytes.

Source files
------------

// File: rtl/tx_frame_scheduler.sv
// tx_frame_scheduler: sends a 16-bit word to a UART as four tagged hex-digit bytes.
// Digits go out from digit 3 down to digit 0. Each byte is {idx[1:0], 2'b00, nibble}.
// The block waits for the UART busy handshake after every byte. It inserts a
// fixed idle gap between the bytes of one frame.
module tx_frame_scheduler #(
    parameter int unsigned GAP_CYCLES   = 16,
    parameter int unsigned BUSY_TIMEOUT = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] word_in,
    input  logic        word_valid,
    output logic        word_ready,
    output logic [7:0]  Tx_DATA,
    output logic        Tx_WR,
    output logic        Tx_EN,
    input  logic        Tx_BUSY,
    output logic        frame_done,
    output logic        frame_err,
    output logic [7:0]  words_sent
);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        WAIT_HI,
        WAIT_LO,
        GAP,
        DONE
    } state_t;

    // Terminal counter values. The counter starts at 0 on entry to a timed
    // state, so a state that lasts N clocks ends when the counter reaches N-1.
    localparam logic [7:0] TIMEOUT_LAST = 8'(BUSY_TIMEOUT - 1);
    localparam logic [7:0] GAP_LAST     = 8'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_t      state, state_n;
    logic [1:0]  idx, idx_n;
    logic [7:0]  cnt, cnt_n;
    logic [15:0] word_q, word_n;
    logic [7:0]  words_n;
    logic [3:0]  nibble;

    // Select the hex digit for the current byte from the holding register.
    always_comb nibble = word_q[{idx, 2'b00} +: 4];

    // State and datapath registers, all cleared by the synchronous reset.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments. Every register
        // then samples pre-edge values, whatever order the blocks run in.
        if (reset) begin
            state      <= IDLE;
            idx        <= 2'd3;
            cnt        <= '0;
            word_q     <= '0;
            words_sent <= '0;
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            cnt        <= cnt_n;
            word_q     <= word_n;
            words_sent <= words_n;
        end
    end

    // Next-state logic plus the outputs decoded from the state and the busy input.
    always_comb begin
        // NOTE: every signal gets a default before the case statement. A path
        // that leaves a signal unassigned would otherwise infer a latch.
        state_n    = state;
        idx_n      = idx;
        cnt_n      = cnt;
        word_n     = word_q;
        words_n    = words_sent;
        word_ready = 1'b0;
        Tx_WR      = 1'b0;
        Tx_EN      = 1'b1;
        Tx_DATA    = {idx, 2'b00, nibble};
        frame_done = 1'b0;
        frame_err  = 1'b0;

        case (state)
            IDLE: begin
                Tx_EN      = 1'b0;
                Tx_DATA    = 8'h00;
                word_ready = 1'b1;
                cnt_n      = '0;
                if (word_valid) begin
                    word_n  = word_in;
                    idx_n   = 2'd3;
                    state_n = WRITE;
                end
            end
            WRITE: begin
                // Hold here without strobing while the UART is still busy.
                // The counter stays cleared so no timeout runs during the hold.
                cnt_n = '0;
                if (!Tx_BUSY) begin
                    Tx_WR   = 1'b1;
                    state_n = WAIT_HI;
                end
            end
            WAIT_HI: begin
                if (Tx_BUSY) begin
                    cnt_n   = '0;
                    state_n = WAIT_LO;
                end else if (cnt == TIMEOUT_LAST) begin
                    frame_err = 1'b1;
                    state_n   = IDLE;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            WAIT_LO: begin
                if (!Tx_BUSY) begin
                    if (idx == 2'd0) begin
                        state_n = DONE;
                    end else if (GAP_CYCLES == 0) begin
                        idx_n   = idx - 2'd1;
                        state_n = WRITE;
                    end else begin
                        cnt_n   = '0;
                        state_n = GAP;
                    end
                end
            end
            GAP: begin
                if (cnt == GAP_LAST) begin
                    cnt_n   = '0;
                    idx_n   = idx - 2'd1;
                    state_n = WRITE;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            DONE: begin
                frame_done = 1'b1;
                words_n    = words_sent + 8'd1;
                state_n    = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_tx_frame_scheduler.sv
// Testbench for tx_frame_scheduler. Instance "a" uses the default parameters.
// Instance "b" runs with no inter-byte gap and a short busy timeout.
// A small UART model drives each instance's busy input.
module tb_tx_frame_scheduler;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Instance a signals
    logic        rst_a = 1'b1, val_a = 1'b0, ready_a, wr_a, en_a, busy_a, done_a, err_a;
    logic [15:0] win_a = '0;
    logic [7:0]  data_a, sent_a;
    // Instance b signals
    logic        rst_b = 1'b1, val_b = 1'b0, ready_b, wr_b, en_b, busy_b, done_b, err_b;
    logic [15:0] win_b = '0;
    logic [7:0]  data_b, sent_b;

    tx_frame_scheduler dut_a (
        .clock(clock), .reset(rst_a), .word_in(win_a), .word_valid(val_a), .word_ready(ready_a),
        .Tx_DATA(data_a), .Tx_WR(wr_a), .Tx_EN(en_a), .Tx_BUSY(busy_a),
        .frame_done(done_a), .frame_err(err_a), .words_sent(sent_a)
    );

    tx_frame_scheduler #(.GAP_CYCLES(0), .BUSY_TIMEOUT(8)) dut_b (
        .clock(clock), .reset(rst_b), .word_in(win_b), .word_valid(val_b), .word_ready(ready_b),
        .Tx_DATA(data_b), .Tx_WR(wr_b), .Tx_EN(en_b), .Tx_BUSY(busy_b),
        .frame_done(done_b), .frame_err(err_b), .words_sent(sent_b)
    );

    // UART models: busy rises the clock after a write strobe and stays high for blen clocks.
    bit auto_a = 1'b1, auto_b = 1'b1, force_b = 1'b0;
    int blen_a = 10, blen_b = 2;
    int left_a = 0, left_b = 0;
    always @(posedge clock) begin
        if (wr_a && auto_a) left_a <= blen_a;
        else if (left_a > 0) left_a <= left_a - 1;
        if (wr_b && auto_b) left_b <= blen_b;
        else if (left_b > 0) left_b <= left_b - 1;
    end
    assign busy_a = (left_a != 0);
    assign busy_b = force_b || (left_b != 0);

    // Monitors sample mid-cycle on the falling edge.
    int wr_cnt_a = 0, done_cnt_a = 0, err_cnt_a = 0, acc_cnt_a = 0, viol_a = 0, fall_a = -1;
    int wr_cnt_b = 0, done_cnt_b = 0, err_cnt_b = 0, viol_b = 0;
    int wr_cyc_a[$], done_cyc_a[$], err_cyc_a[$], acc_cyc_a[$], gaps_a[$];
    logic [7:0] bytes_a[$], bytes_b[$];
    logic busy_prev_a = 1'b0;

    // Monitor for instance a: handshakes, strobes, pulses, and intra-frame gaps.
    always @(negedge clock) begin
        if (val_a && ready_a) begin
            acc_cnt_a <= acc_cnt_a + 1;
            acc_cyc_a.push_back(cyc);
        end
        if (wr_a) begin
            wr_cnt_a <= wr_cnt_a + 1;
            wr_cyc_a.push_back(cyc);
            bytes_a.push_back(data_a);
            if (busy_a) viol_a <= viol_a + 1;
            if (data_a[7:6] != 2'b11 && fall_a >= 0) gaps_a.push_back(cyc - fall_a - 1);
        end
        if (busy_prev_a && !busy_a) fall_a <= cyc;
        busy_prev_a <= busy_a;
        if (done_a) begin
            done_cnt_a <= done_cnt_a + 1;
            done_cyc_a.push_back(cyc);
        end
        if (err_a) begin
            err_cnt_a <= err_cnt_a + 1;
            err_cyc_a.push_back(cyc);
        end
    end

    // Monitor for instance b.
    always @(negedge clock) begin
        if (wr_b) begin
            wr_cnt_b <= wr_cnt_b + 1;
            bytes_b.push_back(data_b);
            if (busy_b) viol_b <= viol_b + 1;
        end
        if (done_b) done_cnt_b <= done_cnt_b + 1;
        if (err_b) err_cnt_b <= err_cnt_b + 1;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        rst_a = 1'b1; rst_b = 1'b1; val_a = 1'b0; val_b = 1'b0;
        repeat (3) tick();
        checks++; if (ready_a !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b expected 1", ready_a); end
        checks++; if (wr_a !== 1'b0) begin errors++; $display("FAIL reset_wr: got %0b expected 0", wr_a); end
        checks++; if (en_a !== 1'b0) begin errors++; $display("FAIL reset_en: got %0b expected 0", en_a); end
        checks++; if (data_a !== 8'h00) begin errors++; $display("FAIL reset_data: got %02h expected 00", data_a); end
        checks++; if (done_a !== 1'b0 || err_a !== 1'b0) begin errors++; $display("FAIL reset_pulses: got done=%0b err=%0b expected 0 0", done_a, err_a); end
        checks++; if (sent_a !== 8'h00) begin errors++; $display("FAIL reset_sent: got %0d expected 0", sent_a); end
        checks++; if (en_b !== 1'b0 || sent_b !== 8'h00) begin errors++; $display("FAIL reset_b: got en=%0b sent=%0d expected 0 0", en_b, sent_b); end
        rst_a = 1'b0; rst_b = 1'b0;
        tick();
    endtask

    task automatic test_nominal();
        logic [7:0] exp [4] = '{8'hCA, 8'h85, 8'h4C, 8'h03};
        int w0 = wr_cnt_a, d0 = done_cnt_a, e0 = err_cnt_a;
        int b0 = bytes_a.size(), g0 = gaps_a.size(), a0 = acc_cyc_a.size();
        auto_a = 1'b1; blen_a = 10;
        win_a = 16'hA5C3; val_a = 1'b1;
        tick();
        val_a = 1'b0; win_a = 16'hFFFF;
        checks++; if (wr_a !== 1'b1 || en_a !== 1'b1 || data_a !== 8'hCA) begin
            errors++; $display("FAIL nominal_first_write: got wr=%0b en=%0b data=%02h expected 1 1 ca", wr_a, en_a, data_a);
        end
        for (int i = 0; i < 300 && done_cnt_a == d0; i++) tick();
        repeat (3) tick();
        checks++; if (done_cnt_a - d0 != 1) begin errors++; $display("FAIL nominal_done_count: got %0d expected 1", done_cnt_a - d0); end
        checks++; if (wr_cnt_a - w0 != 4) begin errors++; $display("FAIL nominal_wr_count: got %0d expected 4", wr_cnt_a - w0); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bytes_a.size() <= b0 + i || bytes_a[b0 + i] !== exp[i]) begin
                errors++; $display("FAIL nominal_byte%0d: got %02h expected %02h", i, bytes_a[b0 + i], exp[i]);
            end
        end
        checks++; if (sent_a !== 8'd1) begin errors++; $display("FAIL nominal_sent: got %0d expected 1", sent_a); end
        checks++; if (err_cnt_a != e0) begin errors++; $display("FAIL nominal_err: got %0d expected 0", err_cnt_a - e0); end
        // 4*(1+1+10) + 3*16 + 1 = 97 clocks from acceptance to frame_done
        checks++;
        if (done_cyc_a.size() == 0 || acc_cyc_a.size() <= a0 || done_cyc_a[$] - acc_cyc_a[a0] != 97) begin
            errors++; $display("FAIL nominal_latency: got %0d expected 97", done_cyc_a[$] - acc_cyc_a[a0]);
        end
        checks++; if (gaps_a.size() - g0 != 3) begin errors++; $display("FAIL nominal_gap_count: got %0d expected 3", gaps_a.size() - g0); end
        for (int i = g0; i < gaps_a.size(); i++) begin
            checks++; if (gaps_a[i] != 16) begin errors++; $display("FAIL nominal_gap: got %0d expected 16", gaps_a[i]); end
        end
    endtask

    task automatic test_timeout();
        int w0, d0 = done_cnt_a, e0 = err_cnt_a;
        auto_a = 1'b0;
        tick();
        w0 = wr_cnt_a;
        win_a = 16'h1234; val_a = 1'b1;
        tick();
        val_a = 1'b0;
        for (int i = 0; i < 200 && err_cnt_a == e0; i++) tick();
        checks++; if (err_cnt_a - e0 != 1) begin errors++; $display("FAIL timeout_err_count: got %0d expected 1", err_cnt_a - e0); end
        checks++;
        if (err_cyc_a.size() == 0 || wr_cyc_a.size() == 0 || err_cyc_a[$] - wr_cyc_a[$] != 64) begin
            errors++; $display("FAIL timeout_latency: got %0d expected 64", err_cyc_a[$] - wr_cyc_a[$]);
        end
        checks++; if (ready_a !== 1'b1) begin errors++; $display("FAIL timeout_ready: got %0b expected 1", ready_a); end
        checks++; if (wr_cnt_a - w0 != 1) begin errors++; $display("FAIL timeout_wr_count: got %0d expected 1", wr_cnt_a - w0); end
        checks++; if (sent_a !== 8'd1 || done_cnt_a != d0) begin errors++; $display("FAIL timeout_sent: got sent=%0d done=%0d expected 1 0", sent_a, done_cnt_a - d0); end
        auto_a = 1'b1;
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp [8] = '{8'hC1, 8'h81, 8'h41, 8'h01, 8'hC2, 8'h82, 8'h42, 8'h02};
        int a0, d0, dq0, b0, g0, e0, bad;
        rst_a = 1'b1; tick(); tick(); rst_a = 1'b0;
        blen_a = 3;
        a0 = acc_cnt_a; d0 = done_cnt_a; dq0 = done_cyc_a.size(); b0 = bytes_a.size();
        g0 = gaps_a.size(); e0 = err_cnt_a;
        win_a = 16'h1111; val_a = 1'b1;
        for (int i = 0; i < 400 && (acc_cnt_a - a0) < 2; i++) begin
            tick();
            if (acc_cnt_a - a0 == 1) win_a = 16'h2222;
        end
        val_a = 1'b0;
        for (int i = 0; i < 400 && (done_cnt_a - d0) < 2; i++) tick();
        checks++; if (acc_cnt_a - a0 != 2) begin errors++; $display("FAIL b2b_accepts: got %0d expected 2", acc_cnt_a - a0); end
        checks++; if (done_cnt_a - d0 != 2) begin errors++; $display("FAIL b2b_done_count: got %0d expected 2", done_cnt_a - d0); end
        checks++; if (sent_a !== 8'd2) begin errors++; $display("FAIL b2b_sent: got %0d expected 2", sent_a); end
        checks++;
        if (done_cyc_a.size() <= dq0 || acc_cyc_a.size() < 2 || acc_cyc_a[$] < done_cyc_a[dq0] + 1) begin
            errors++; $display("FAIL b2b_second_accept: got cycle %0d expected >= %0d", acc_cyc_a[$], done_cyc_a[dq0] + 1);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (bytes_a.size() <= b0 + i || bytes_a[b0 + i] !== exp[i]) begin
                errors++; $display("FAIL b2b_byte%0d: got %02h expected %02h", i, bytes_a[b0 + i], exp[i]);
            end
        end
        bad = 0;
        for (int i = g0; i < gaps_a.size(); i++) if (gaps_a[i] < 16) bad++;
        checks++; if (bad != 0 || gaps_a.size() - g0 != 6) begin errors++; $display("FAIL b2b_gaps: got %0d short of %0d expected 0 short of 6", bad, gaps_a.size() - g0); end
        checks++; if (err_cnt_a != e0) begin errors++; $display("FAIL b2b_err: got %0d expected 0", err_cnt_a - e0); end
    endtask

    task automatic test_mid_reset();
        int w0 = wr_cnt_a, d0 = done_cnt_a, e0 = err_cnt_a;
        blen_a = 10;
        win_a = 16'hA5C3; val_a = 1'b1;
        tick();
        val_a = 1'b0;
        for (int i = 0; i < 200 && (wr_cnt_a - w0) < 2; i++) tick();
        // Now in WAIT_HI of byte idx=2 with busy high; three more clocks lands in WAIT_LO.
        repeat (3) tick();
        rst_a = 1'b1;
        tick();
        checks++; if (ready_a !== 1'b1 || en_a !== 1'b0 || wr_a !== 1'b0) begin
            errors++; $display("FAIL midrst_ctrl: got ready=%0b en=%0b wr=%0b expected 1 0 0", ready_a, en_a, wr_a);
        end
        checks++; if (data_a !== 8'h00 || sent_a !== 8'h00) begin
            errors++; $display("FAIL midrst_data: got data=%02h sent=%0d expected 00 0", data_a, sent_a);
        end
        rst_a = 1'b0;
        repeat (40) tick();
        checks++; if (wr_cnt_a - w0 != 2) begin errors++; $display("FAIL midrst_no_wr: got %0d expected 2", wr_cnt_a - w0); end
        checks++; if (done_cnt_a != d0 || err_cnt_a != e0) begin
            errors++; $display("FAIL midrst_pulses: got done=%0d err=%0d expected 0 0", done_cnt_a - d0, err_cnt_a - e0);
        end
        win_a = 16'h7000; val_a = 1'b1;
        tick();
        val_a = 1'b0;
        checks++; if (wr_a !== 1'b1 || data_a !== 8'hC7) begin errors++; $display("FAIL midrst_restart: got wr=%0b data=%02h expected 1 c7", wr_a, data_a); end
    endtask

    task automatic test_gap0_busy();
        logic [7:0] exp [4] = '{8'hC9, 8'h88, 8'h47, 8'h06};
        int w0 = wr_cnt_b, d0 = done_cnt_b, e0 = err_cnt_b, b0 = bytes_b.size();
        force_b = 1'b1; auto_b = 1'b1; blen_b = 2;
        win_b = 16'h9876; val_b = 1'b1;
        tick();
        val_b = 1'b0;
        checks++; if (wr_b !== 1'b0 || en_b !== 1'b1 || data_b !== 8'hC9) begin
            errors++; $display("FAIL gap0_hold: got wr=%0b en=%0b data=%02h expected 0 1 c9", wr_b, en_b, data_b);
        end
        repeat (20) tick();
        checks++; if (wr_cnt_b != w0 || err_cnt_b != e0) begin
            errors++; $display("FAIL gap0_held: got wr=%0d err=%0d expected 0 0", wr_cnt_b - w0, err_cnt_b - e0);
        end
        force_b = 1'b0;
        for (int i = 0; i < 200 && done_cnt_b == d0; i++) tick();
        checks++; if (wr_cnt_b - w0 != 4 || done_cnt_b - d0 != 1) begin
            errors++; $display("FAIL gap0_frame: got wr=%0d done=%0d expected 4 1", wr_cnt_b - w0, done_cnt_b - d0);
        end
        checks++; if (err_cnt_b != e0) begin errors++; $display("FAIL gap0_err: got %0d expected 0", err_cnt_b - e0); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bytes_b.size() <= b0 + i || bytes_b[b0 + i] !== exp[i]) begin
                errors++; $display("FAIL gap0_byte%0d: got %02h expected %02h", i, bytes_b[b0 + i], exp[i]);
            end
        end
        checks++; if (sent_b !== 8'd1) begin errors++; $display("FAIL gap0_sent: got %0d expected 1", sent_b); end
    endtask

    task automatic test_wrap();
        int d0;
        rst_b = 1'b1; tick(); tick(); rst_b = 1'b0;
        d0 = done_cnt_b; blen_b = 1;
        win_b = 16'h0001; val_b = 1'b1;
        for (int i = 0; i < 6000 && (done_cnt_b - d0) < 255; i++) tick();
        checks++; if (sent_b !== 8'd255) begin errors++; $display("FAIL wrap_255: got %0d expected 255", sent_b); end
        for (int i = 0; i < 100 && (done_cnt_b - d0) < 256; i++) tick();
        val_b = 1'b0;
        checks++; if (sent_b !== 8'h00) begin errors++; $display("FAIL wrap_zero: got %0d expected 0", sent_b); end
        repeat (20) tick();
        checks++; if (done_cnt_b - d0 != 256) begin errors++; $display("FAIL wrap_pulses: got %0d expected 256", done_cnt_b - d0); end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_timeout();
        test_back_to_back();
        test_mid_reset();
        test_gap0_busy();
        test_wrap();
        checks++; if (viol_a != 0 || viol_b != 0) begin errors++; $display("FAIL wr_while_busy: got %0d/%0d expected 0/0", viol_a, viol_b); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
